// File: rtl/gpio_pkg.sv
// GPIO MMIO shared definitions.
// Register offsets inside the 32-byte window and the decoder.
package gpio_pkg;

    localparam int WIN_BYTES = 32;

    localparam logic [4:0] OFS_IN  = 5'h00;
    localparam logic [4:0] OFS_OUT = 5'h04;
    localparam logic [4:0] OFS_TGL = 5'h08;
    localparam logic [4:0] OFS_EN  = 5'h0C;
    localparam logic [4:0] OFS_STS = 5'h10;

    typedef enum logic [2:0] {
        REG_IN,
        REG_OUT,
        REG_TGL,
        REG_EN,
        REG_STS,
        REG_NONE
    } reg_e;

    // Byte lane bits [1:0] do not take part in register selection.
    function automatic reg_e decode(input logic [4:0] ofs);
        reg_e r;
        r = REG_NONE;
        if (ofs[4:2] == OFS_IN[4:2])  r = REG_IN;
        if (ofs[4:2] == OFS_OUT[4:2]) r = REG_OUT;
        if (ofs[4:2] == OFS_TGL[4:2]) r = REG_TGL;
        if (ofs[4:2] == OFS_EN[4:2])  r = REG_EN;
        if (ofs[4:2] == OFS_STS[4:2]) r = REG_STS;
        return r;
    endfunction

endpackage

// File: rtl/gpio_mmio_if.sv
// Processor data-bus slice seen by the GPIO block.
// The master drives the store/address side, the slave answers.
interface gpio_mmio_if;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        sel;

    modport master (
        output MemWrite, DataAdr, WriteData,
        input  ReadData, sel
    );

    modport slave (
        input  MemWrite, DataAdr, WriteData,
        output ReadData, sel
    );
endinterface

// File: rtl/gpio_debounce.sv
// One switch channel: 2-flop synchronizer plus stability counter.
// rise pulses on the edge where the debounced bit goes 0->1.
module gpio_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic nreset,
    input  logic din,
    output logic dout,
    output logic rise
);
    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic          deb;
    logic [CW-1:0] cnt;
    logic          hit;

    // The increment that would reach DEB_CYCLES accepts the value.
    assign hit  = (s2 != deb) && (cnt == CNT_LAST);
    assign rise = hit & s2;
    assign dout = deb;

    // Synchronize, then count consecutive cycles of disagreement.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            deb <= 1'b0;
            cnt <= '0;
        end else begin
            s1 <= din;
            s2 <= s1;
            if (s2 == deb) begin
                cnt <= '0;
            end else if (hit) begin
                deb <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/gpio_mmio.sv
// Memory-mapped GPIO: debounced switch inputs, led outputs,
// rising-edge status with interrupt, in a 32-byte window.
module gpio_mmio
    import gpio_pkg::*;
#(
    parameter int          NIN        = 10,
    parameter int          NOUT       = 10,
    parameter int          DEB_CYCLES = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0400
) (
    input  logic            clk,
    input  logic            nreset,
    gpio_mmio_if.slave      bus,
    input  logic [NIN-1:0]  switches,
    output logic [NOUT-1:0] leds,
    output logic            irq
);
    logic [NIN-1:0]  in_q;
    logic [NIN-1:0]  rise;
    logic [NOUT-1:0] out_q;
    logic [NIN-1:0]  en_q;
    logic [NIN-1:0]  sts_q;
    logic [NIN-1:0]  clr;
    logic [NOUT-1:0] wd_out;
    logic [NIN-1:0]  wd_in;
    logic            hit_win;
    logic            we;
    reg_e            rsel;
    logic [31:0]     rdata;
    logic            unused_bits;

    assign hit_win = bus.DataAdr[31:5] == BASE_ADDR[31:5];
    assign rsel    = decode(bus.DataAdr[4:0]);
    assign we      = bus.MemWrite & hit_win;
    assign wd_out  = bus.WriteData[NOUT-1:0];
    assign wd_in   = bus.WriteData[NIN-1:0];

    assign unused_bits = ^{bus.DataAdr[1:0], bus.WriteData};

    assign bus.sel      = hit_win;
    assign bus.ReadData = rdata;
    assign leds         = out_q;
    assign irq          = |sts_q;

    for (genvar i = 0; i < NIN; i++) begin : g_in
        gpio_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .clk    (clk),
            .nreset (nreset),
            .din    (switches[i]),
            .dout   (in_q[i]),
            .rise   (rise[i])
        );
    end

    // OUT: plain store or XOR toggle.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            out_q <= '0;
        end else if (we && rsel == REG_OUT) begin
            out_q <= wd_out;
        end else if (we && rsel == REG_TGL) begin
            out_q <= out_q ^ wd_out;
        end
    end

    // EDGE_EN: plain read/write mask.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            en_q <= '0;
        end else if (we && rsel == REG_EN) begin
            en_q <= wd_in;
        end
    end

    assign clr = (we && rsel == REG_STS) ? wd_in : '0;

    // EDGE_STS: sticky rise flags, W1C; a new rise beats a clear.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sts_q <= '0;
        end else begin
            sts_q <= (sts_q & ~clr) | (rise & en_q);
        end
    end

    // Read mux reflects current register state, zero-extended.
    always_comb begin
        rdata = '0;
        if (hit_win) begin
            case (rsel)
                REG_IN:  rdata = 32'(in_q);
                REG_OUT: rdata = 32'(out_q);
                REG_EN:  rdata = 32'(en_q);
                REG_STS: rdata = 32'(sts_q);
                default: rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_mmio.sv
// Directed bench for gpio_mmio: register vector table plus
// hand sequences for debounce timing, edge status and reset.
module tb_gpio_mmio;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_sel;
    } vec_t;

    logic       clk;
    logic       nreset;
    logic [9:0] switches;
    logic [9:0] leds;
    logic       irq;
    int         nvec;
    int         nerr;
    int         h;
    vec_t       tab [19];

    gpio_mmio_if bus ();

    gpio_mmio #(
        .NIN        (10),
        .NOUT       (10),
        .DEB_CYCLES (4),
        .BASE_ADDR  (32'h0000_0400)
    ) dut (
        .clk      (clk),
        .nreset   (nreset),
        .bus      (bus.slave),
        .switches (switches),
        .leds     (leds),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic rd(input string name, input logic [31:0] adr,
                      input logic [31:0] exp);
        bus.MemWrite = 1'b0;
        bus.DataAdr  = adr;
        #1;
        chk(name, bus.ReadData, exp);
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] d);
        @(negedge clk);
        bus.MemWrite  = 1'b1;
        bus.DataAdr   = adr;
        bus.WriteData = d;
        @(posedge clk);
        #1;
        bus.MemWrite = 1'b0;
    endtask

    // Edge count (1-based) at which IN[b] first reads 1, 0 if never.
    task automatic first_edge(input int b, output int k_hit);
        bus.MemWrite = 1'b0;
        bus.DataAdr  = 32'h400;
        k_hit = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (k_hit == 0 && bus.ReadData[b]) k_hit = k;
        end
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        tab[0]  = '{1'b0, 32'h404, 32'h0,        32'h000, 1'b1};
        tab[1]  = '{1'b1, 32'h404, 32'h3FF,      32'h000, 1'b1};
        tab[2]  = '{1'b1, 32'h408, 32'h00F,      32'h000, 1'b1};
        tab[3]  = '{1'b0, 32'h404, 32'h0,        32'h3F0, 1'b1};
        tab[4]  = '{1'b0, 32'h408, 32'h0,        32'h000, 1'b1};
        tab[5]  = '{1'b1, 32'h40C, 32'hFFFFFFFF, 32'h000, 1'b1};
        tab[6]  = '{1'b0, 32'h40C, 32'h0,        32'h3FF, 1'b1};
        tab[7]  = '{1'b1, 32'h40C, 32'h004,      32'h3FF, 1'b1};
        tab[8]  = '{1'b0, 32'h40C, 32'h0,        32'h004, 1'b1};
        tab[9]  = '{1'b1, 32'h41C, 32'h1234,     32'h000, 1'b1};
        tab[10] = '{1'b0, 32'h41C, 32'h0,        32'h000, 1'b1};
        tab[11] = '{1'b1, 32'h500, 32'hFFFF,     32'h000, 1'b0};
        tab[12] = '{1'b0, 32'h407, 32'h0,        32'h3F0, 1'b1};
        tab[13] = '{1'b0, 32'h410, 32'h0,        32'h000, 1'b1};
        tab[14] = '{1'b0, 32'h3FC, 32'h0,        32'h000, 1'b0};
        tab[15] = '{1'b1, 32'h404, 32'hFFFFFFFF, 32'h3F0, 1'b1};
        tab[16] = '{1'b0, 32'h404, 32'h0,        32'h3FF, 1'b1};
        tab[17] = '{1'b1, 32'h408, 32'h00F,      32'h000, 1'b1};
        tab[18] = '{1'b0, 32'h404, 32'h0,        32'h3F0, 1'b1};

        nreset        = 1'b0;
        switches      = '0;
        bus.MemWrite  = 1'b0;
        bus.DataAdr   = 32'h400;
        bus.WriteData = '0;
        #5;
        chk("rst_leds", 32'(leds), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        @(negedge clk);
        nreset = 1'b1;

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            bus.MemWrite  = tab[i].we;
            bus.DataAdr   = tab[i].adr;
            bus.WriteData = tab[i].wd;
            #1;
            chk($sformatf("vec%0d_rd", i), bus.ReadData, tab[i].exp_rd);
            chk($sformatf("vec%0d_sel", i), 32'(bus.sel),
                32'(tab[i].exp_sel));
            @(posedge clk);
            #1;
            bus.MemWrite = 1'b0;
        end
        chk("leds_tab", 32'(leds), 32'h3F0);

        // 3-cycle glitch on switch 2 must never be accepted.
        @(negedge clk);
        switches[2] = 1'b1;
        bus.DataAdr = 32'h400;
        h = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (bus.ReadData[2]) h = 1;
            if (k == 3) begin
                @(negedge clk);
                switches[2] = 1'b0;
            end
        end
        chk("glitch_in", 32'(h), 32'h0);
        rd("glitch_sts", 32'h410, 32'h0);

        // Clean rise on switch 2 with EN[2]=1.
        @(negedge clk);
        switches[2] = 1'b1;
        first_edge(2, h);
        chk("rise2_edge", 32'(h), 32'd6);
        rd("rise2_sts", 32'h410, 32'h004);
        chk("rise2_irq", 32'(irq), 32'h1);

        wr(32'h410, 32'h004);
        rd("w1c_sts", 32'h410, 32'h0);
        chk("w1c_irq", 32'(irq), 32'h0);

        // Rise on switch 3 while EN[3]=0.
        @(negedge clk);
        switches[3] = 1'b1;
        first_edge(3, h);
        chk("rise3_edge", 32'(h), 32'd6);
        rd("rise3_sts", 32'h410, 32'h0);
        rd("rise3_in", 32'h400, 32'h00C);

        // Falling edge sets nothing.
        @(negedge clk);
        switches[2] = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rd("fall2_in", 32'h400, 32'h008);
        rd("fall2_sts", 32'h410, 32'h0);

        // W1C on the very edge bit 2 rises: set wins.
        @(negedge clk);
        switches[2] = 1'b1;
        repeat (5) @(posedge clk);
        wr(32'h410, 32'h004);
        rd("race_in", 32'h400, 32'h00C);
        rd("race_sts", 32'h410, 32'h004);
        chk("race_irq", 32'(irq), 32'h1);

        // Asynchronous reset mid-run, checked between edges.
        @(negedge clk);
        #2;
        nreset = 1'b0;
        #1;
        chk("arst_leds", 32'(leds), 32'h0);
        chk("arst_irq", 32'(irq), 32'h0);
        rd("arst_in", 32'h400, 32'h0);
        rd("arst_out", 32'h404, 32'h0);
        rd("arst_tgl", 32'h408, 32'h0);
        rd("arst_en", 32'h40C, 32'h0);
        rd("arst_sts", 32'h410, 32'h0);

        // Held switch is re-accepted after release.
        @(negedge clk);
        nreset = 1'b1;
        first_edge(2, h);
        chk("rel_edge", 32'(h), 32'd6);
        rd("rel_sts", 32'h410, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/gpio_mmio.md
GPIO_MMIO -- requirements
Module: gpio_mmio

Interface
REQ-001 Parameter: NIN, 10, number of input channels (switches), legal 1..32.
REQ-002 Parameter: NOUT, 10, number of output channels (leds), legal 1..32.
REQ-003 Parameter: DEB_CYCLES, 4, consecutive stable cycles required before an input change is accepted, legal >=1.
REQ-004 Parameter: BASE_ADDR, 32'h0000_0400, byte base of the 32-byte register window, 32-byte aligned.
REQ-005 Port: clk  input  1  single system clock, all state on rising edge.
REQ-006 Port: nreset  input  1  reset, asynchronous, active-low.
REQ-007 Port: MemWrite  input  1  processor store strobe.
REQ-008 Port: DataAdr  input  32  processor byte address.
REQ-009 Port: WriteData  input  32  processor store data.
REQ-010 Port: ReadData  output  32  register read data, combinational.
REQ-011 Port: sel  output  1  high when DataAdr falls in the window, for dmem read mux.
REQ-012 Port: switches  input  NIN  asynchronous external inputs.
REQ-013 Port: leds  output  NOUT  driven directly from OUT register.
REQ-014 Port: irq  output  1  OR of all EDGE_STS bits.

Function
REQ-015 sel SHALL be high iff DataAdr[31:5] == BASE_ADDR[31:5]; DataAdr[1:0] ignored.
REQ-016 Map SHALL be: +0x00 IN (RO), +0x04 OUT (RW), +0x08 OUT_TGL (WO, reads 0), +0x0C EDGE_EN (RW), +0x10 EDGE_STS (R/W1C); other offsets read 0, writes ignored.
REQ-017 Register bits above NIN/NOUT SHALL read 0 and ignore writes.
REQ-018 Writes SHALL take effect on the rising clk edge where MemWrite && sel; reads SHALL be combinational, same cycle, reflecting pre-edge state.
REQ-019 OUT_TGL write SHALL XOR WriteData[NOUT-1:0] into OUT.
REQ-020 Each switch SHALL pass through a 2-flop synchronizer, then a per-channel debouncer.
REQ-021 Debouncer: counter clears when synced bit equals debounced bit; otherwise increments; when it reaches DEB_CYCLES, debounced bit takes synced value and counter clears, same edge.
REQ-022 IN SHALL show a clean switch change exactly DEB_CYCLES+2 rising edges after the change is first sampled; glitches shorter than DEB_CYCLES cycles after sync SHALL never appear.
REQ-023 A 0->1 transition of debounced bit i SHALL set EDGE_STS[i] on that edge iff EDGE_EN[i] is 1 at that edge.
REQ-024 W1C write to EDGE_STS SHALL clear bits where WriteData is 1; simultaneous set and clear of the same bit: set wins.
REQ-025 Clearing EDGE_EN[i] SHALL NOT clear EDGE_STS[i].
REQ-026 irq SHALL equal |EDGE_STS, combinational from the register.

Reset
REQ-027 nreset low SHALL immediately clear OUT, EDGE_EN, EDGE_STS, sync flops, debounced bits and counters; leds=0, irq=0 without a clock.
REQ-028 Reset mid-debounce SHALL abandon the count; after release, a held switch is accepted DEB_CYCLES+2 edges later.
REQ-029 Release of nreset SHALL be consumed by the codebase's external synchronizer; this block adds none.

Structure
REQ-030 Package gpio_pkg SHALL hold offset constants (OFS_IN, OFS_OUT, OFS_TGL, OFS_EN, OFS_STS) and window size 32.
REQ-031 Sub-module gpio_debounce (1-bit synchronizer + counter of width $clog2(DEB_CYCLES+1)) SHALL be instantiated NIN times via generate.
REQ-032 Block SHALL replace the fixed switch/led logic inside dmem; top passes switches/leds and parameters through.

Verification (NIN=NOUT=10, DEB_CYCLES=4, BASE=0x400)
REQ-033 Reset: nreset low mid-run -> leds=0, irq=0, read 0x400..0x410 all 0 without clock edge.
REQ-034 Store 0x3FF to 0x404, then 0x00F to 0x408 -> leds=0x3F0; read 0x404 = 0x3F0; read 0x408 = 0.
REQ-035 switches[2] 0->1 held -> read 0x400 bit2 = 1 exactly 6 edges after first sample; 3-cycle pulse -> bit2 never set.
REQ-036 EDGE_EN=0x004, switch2 rises -> EDGE_STS=0x004, irq=1; store 0x004 to 0x410 -> 0, irq=0; switch3 rises with EN[3]=0 -> status 0.
REQ-037 W1C to bit2 on same edge debounced bit2 rises -> EDGE_STS[2] stays 1.
REQ-038 Store to 0x41C and 0x500 -> no state change; read 0x41C = 0, sel=1; read 0x500 sel=0.
